// File: rtl/fft_pc_pkg.sv
// fft_pc_pkg: shared defaults, bank-state encoding and complex word packing for the 2D FFT corner turn.
package fft_pc_pkg;

    localparam int unsigned N_DEF      = 128;
    localparam int unsigned LOG2N_DEF  = 7;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    typedef struct packed {
        logic [15:0] im;
        logic [15:0] re;
    } cplx_t;

    function automatic logic [31:0] pack_cplx(input logic [15:0] im, input logic [15:0] re);
        cplx_t c;
        c.im = im;
        c.re = re;
        return c;
    endfunction

    function automatic cplx_t unpack_cplx(input logic [31:0] w);
        return cplx_t'(w);
    endfunction

endpackage

// File: rtl/fft_sdp_ram.sv
// fft_sdp_ram: simple dual-port RAM, one write port, one read port with 1-cycle registered read.
module fft_sdp_ram
    import fft_pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_corner_turn_buffer.sv
// fft_corner_turn_buffer: ping-pong NxN corner turn, row-major AXI-Stream in, column-major out.
// Optional TLAST_CHECK_EN adds a sticky flag for s_tlast not marking the end of an input row.
module fft_corner_turn_buffer
    import fft_pc_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LOG2N  = LOG2N_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              m_frame_last,
    output logic              err_tlast
);

    localparam int unsigned AW = 2 * LOG2N + 1;

    if ((1 << LOG2N) != N || LOG2N < 2) begin : g_bad_geometry
        $error("fft_corner_turn_buffer: N must equal 2**LOG2N and be at least 4");
    end

    typedef struct packed {
        logic              frame_last;
        logic              last;
        logic [DATA_W-1:0] data;
    } out_ent_t;

    bank_state_t       bank_state [2];
    logic              wr_bank, rd_bank, ready_en;
    logic [LOG2N-1:0]  wr_row, wr_col, rd_row, rd_col;
    logic              wr_fire, wr_last, readable, pop, rd_issue, rd_last;
    logic [1:0]        occ;
    logic              rv, rv_last, rv_flast;
    logic [DATA_W-1:0] rd_data;
    out_ent_t          ent0, ent1, ent_new;
    logic              v0, v1;

    assign s_tready = ready_en && (bank_state[wr_bank] != BANK_FULL)
                      && (bank_state[wr_bank] != BANK_DRAINING);
    assign wr_fire  = s_tvalid && s_tready;
    assign wr_last  = (&wr_row) && (&wr_col);
    assign readable = (bank_state[rd_bank] == BANK_FULL) || (bank_state[rd_bank] == BANK_DRAINING);
    assign pop      = v0 && m_tready;
    // Words already in flight from the RAM count against the 2-entry output stage.
    assign occ      = {1'b0, v0} + {1'b0, v1} + {1'b0, rv};
    assign rd_issue = readable && ((occ < 2'd2) || ((occ == 2'd2) && pop));
    assign rd_last  = (&rd_row) && (&rd_col);

    fft_sdp_ram #(
        .ADDR_W(AW),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_fire),
        .wr_addr({wr_bank, wr_row, wr_col}),
        .wr_data(s_tdata),
        .rd_en  (rd_issue),
        .rd_addr({rd_bank, rd_row, rd_col}),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_row        <= '0;
            wr_col        <= '0;
            rd_row        <= '0;
            rd_col        <= '0;
            ready_en      <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (wr_fire) begin
                wr_col <= wr_col + 1'b1;
                if (&wr_col) begin
                    wr_row <= wr_row + 1'b1;
                end
                if (wr_last) begin
                    bank_state[wr_bank] <= BANK_FULL;
                    wr_bank             <= ~wr_bank;
                end else if (bank_state[wr_bank] == BANK_EMPTY) begin
                    bank_state[wr_bank] <= BANK_FILLING;
                end
            end
            // A bank is released once its last word has left the RAM; the tail
            // sits in the output stage, so the next frame can refill it at once.
            if (rd_issue) begin
                rd_row <= rd_row + 1'b1;
                if (&rd_row) begin
                    rd_col <= rd_col + 1'b1;
                end
                if (rd_last) begin
                    bank_state[rd_bank] <= BANK_EMPTY;
                    rd_bank             <= ~rd_bank;
                end else if (bank_state[rd_bank] == BANK_FULL) begin
                    bank_state[rd_bank] <= BANK_DRAINING;
                end
            end
        end
    end

    assign ent_new = {rv_flast, rv_last, rd_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rv       <= 1'b0;
            rv_last  <= 1'b0;
            rv_flast <= 1'b0;
            v0       <= 1'b0;
            v1       <= 1'b0;
            ent0     <= '0;
            ent1     <= '0;
        end else begin
            rv       <= rd_issue;
            rv_last  <= &rd_row;
            rv_flast <= rd_last;
            if (pop) begin
                if (v1) begin
                    ent0 <= ent1;
                    if (rv) begin
                        ent1 <= ent_new;
                    end else begin
                        v1 <= 1'b0;
                    end
                end else if (rv) begin
                    ent0 <= ent_new;
                end else begin
                    v0 <= 1'b0;
                end
            end else if (rv) begin
                if (!v0) begin
                    ent0 <= ent_new;
                    v0   <= 1'b1;
                end else begin
                    ent1 <= ent_new;
                    v1   <= 1'b1;
                end
            end
        end
    end

    assign m_tvalid     = v0;
    assign m_tdata      = ent0.data;
    assign m_tlast      = ent0.last;
    assign m_frame_last = ent0.frame_last;

`ifdef TLAST_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (wr_fire && (s_tlast != (&wr_col))) begin
            err_q <= 1'b1;
        end
    end

    assign err_tlast = err_q;
`else
    logic unused_tlast;

    assign unused_tlast = s_tlast;
    assign err_tlast    = 1'b0;
`endif

endmodule
